// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - decode/execute/writeback signal bundle for issue_ctrl
//
// Shared definitions (register address width, instruction codes) live here so
// that every file in the bundle sees them before use.
//
// Signals:
//   dec_valid, instr_code, rs1, rs2, rd   decoded instruction from decode
//   uses_rs1, uses_rs2, writes_rd         operand / destination qualifiers
//   ex_ready                              execute stage can accept
//   wb_valid, wb_rd                       register writeback completion
//   br_done, br_taken                     control-flow resolution
//   issue, stall, flush                   issue decisions back to the pipeline
//   busy, inflight                        scoreboard state
// Modports: master (pipeline side drives the inputs), slave (issue_ctrl).
`ifndef ISSUE_CTRL_DEFS
`define ISSUE_CTRL_DEFS
`define ASIZE 5
`define ADD   4'd0
`define MUL   4'd1
`define ADDI  4'd2
`define LW    4'd3
`define SW    4'd4
`define JAL   4'd5
`define JR    4'd6
`define BNE   4'd7
`endif

interface issue_ctrl_if;
  logic              dec_valid;
  logic [3:0]        instr_code;
  logic [`ASIZE-1:0] rs1;
  logic [`ASIZE-1:0] rs2;
  logic [`ASIZE-1:0] rd;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              writes_rd;
  logic              ex_ready;
  logic              wb_valid;
  logic [`ASIZE-1:0] wb_rd;
  logic              br_done;
  logic              br_taken;
  logic              issue;
  logic              stall;
  logic              flush;
  logic [31:0]       busy;
  logic [3:0]        inflight;

  modport master (
    output dec_valid, instr_code, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd,
           ex_ready, wb_valid, wb_rd, br_done, br_taken,
    input  issue, stall, flush, busy, inflight
  );

  modport slave (
    input  dec_valid, instr_code, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd,
           ex_ready, wb_valid, wb_rd, br_done, br_taken,
    output issue, stall, flush, busy, inflight
  );
endinterface

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue control with register scoreboard and branch wait
//
// Purpose: decides each cycle whether the decoded instruction may be issued,
// tracks pending register writes in a 32-bit busy vector, limits the number of
// uncompleted writers to MAX_INFLIGHT, and holds issue while a control-flow
// instruction resolves, pulsing flush for one cycle on a taken redirect.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - issue_ctrl_if.slave (decode, execute, writeback, branch, outputs)
//
// Optional feature: define ISSUE_WB_BYPASS_EN to let an operand or destination
// that is being written back this cycle stop counting as a hazard.
module issue_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input logic        clk,
  input logic        rst,
  issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  inflight_q, inflight_d;
  logic        flush_q, flush_d;

  logic [31:0] busy_eff;
  logic        hazard;
  logic        is_branch;
  logic        at_limit;
  logic        set_en;
  logic        clr_en;
  logic        issue_w;

  // Writebacks to x0, or with nothing outstanding, are dropped entirely.
  assign clr_en = bus.wb_valid && (bus.wb_rd != '0) && (inflight_q != 4'd0);

`ifdef ISSUE_WB_BYPASS_EN
  // The register completing this cycle is already free for hazard purposes.
  always_comb begin
    busy_eff = busy_q;
    if (clr_en) busy_eff[bus.wb_rd] = 1'b0;
  end
`else
  assign busy_eff = busy_q;
`endif

  assign hazard = (bus.uses_rs1  && busy_eff[bus.rs1]) ||
                  (bus.uses_rs2  && busy_eff[bus.rs2]) ||
                  (bus.writes_rd && busy_eff[bus.rd]);

  assign is_branch = (bus.instr_code == `JAL) || (bus.instr_code == `JR) ||
                     (bus.instr_code == `BNE);

  assign at_limit = (inflight_q == 4'(MAX_INFLIGHT));

  assign issue_w = bus.dec_valid && bus.ex_ready && !hazard && (state_q == RUN) &&
                   !(bus.writes_rd && (bus.rd != '0) && at_limit);

  assign set_en = issue_w && bus.writes_rd && (bus.rd != '0);

  always_comb begin
    // Clear first so a same-register set in the same cycle wins.
    busy_d = busy_q;
    if (clr_en) busy_d[bus.wb_rd] = 1'b0;
    if (set_en) busy_d[bus.rd] = 1'b1;

    inflight_d = inflight_q;
    case ({set_en, clr_en})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase

    state_d = state_q;
    case (state_q)
      RUN:     if (issue_w && is_branch) state_d = BR_WAIT;
      BR_WAIT: if (bus.br_done) state_d = bus.br_taken ? FLUSH : RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    flush_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      busy_q     <= '0;
      inflight_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      flush_q    <= flush_d;
    end
  end

  assign bus.issue    = issue_w;
  assign bus.stall    = bus.dec_valid && !issue_w;
  assign bus.flush    = flush_q;
  assign bus.busy     = busy_q;
  assign bus.inflight = inflight_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
`ifndef ISSUE_CTRL_DEFS
`define ISSUE_CTRL_DEFS
`define ASIZE 5
`define ADD   4'd0
`define MUL   4'd1
`define ADDI  4'd2
`define LW    4'd3
`define SW    4'd4
`define JAL   4'd5
`define JR    4'd6
`define BNE   4'd7
`endif

module tb_issue_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  issue_ctrl_if bus ();

  issue_ctrl #(.MAX_INFLIGHT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] code,
                       input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub,
                       input logic [4:0] d, input logic wd);
    bus.dec_valid  = v;
    bus.instr_code = code;
    bus.rs1 = a;  bus.uses_rs1 = ua;
    bus.rs2 = b;  bus.uses_rs2 = ub;
    bus.rd  = d;  bus.writes_rd = wd;
    settle();
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    bus.wb_valid = v;
    bus.wb_rd    = r;
    settle();
  endtask

  task automatic idle();
    drive(1'b0, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b0, 5'd0);
    bus.br_done  = 1'b0;
    bus.br_taken = 1'b0;
    bus.ex_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    wb(1'b1, 5'd4);
    step();
    step();
    rst = 1'b0;
    wb(1'b0, 5'd0);
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", bus.busy, 32'h0); end
    checks++; if (bus.inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", bus.inflight); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush); end
    checks++; if (bus.stall !== 1'b0 || bus.issue !== 1'b0) begin errors++; $display("FAIL reset_idle got issue=%b stall=%b exp 0 0", bus.issue, bus.stall); end
  endtask

  task automatic test_raw_hazard();
    // Execute not ready: stall even without hazard.
    bus.ex_ready = 1'b0;
    drive(1'b1, `LW, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    checks++; if (bus.stall !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL exready_stall got issue=%b stall=%b exp 0 1", bus.issue, bus.stall); end
    bus.ex_ready = 1'b1;
    settle();
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL lw_issue got %b exp 1", bus.issue); end
    step();
    drive(1'b1, `ADD, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
    checks++; if (bus.busy !== 32'h20 || bus.inflight !== 4'd1) begin errors++; $display("FAIL lw_busy got %h/%0d exp 00000020/1", bus.busy, bus.inflight); end
    checks++; if (bus.stall !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL raw_stall got issue=%b stall=%b exp 0 1", bus.issue, bus.stall); end
    step();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall2 got %b exp 1", bus.stall); end
    wb(1'b1, 5'd5);
`ifdef ISSUE_WB_BYPASS_EN
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_bypass_issue got %b exp 1", bus.issue); end
    step();
    wb(1'b0, 5'd0);
    drive(1'b0, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
`else
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL raw_wbcycle_issue got %b exp 0", bus.issue); end
    step();
    wb(1'b0, 5'd0);
    checks++; if (bus.busy !== 32'h0 || bus.inflight !== 4'd0) begin errors++; $display("FAIL raw_cleared got %h/%0d exp 00000000/0", bus.busy, bus.inflight); end
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_after_issue got %b exp 1", bus.issue); end
    step();
    drive(1'b0, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
`endif
    checks++; if (bus.busy !== 32'h40 || bus.inflight !== 4'd1) begin errors++; $display("FAIL raw_add_busy got %h/%0d exp 00000040/1", bus.busy, bus.inflight); end
    wb(1'b1, 5'd6);
    step();
    wb(1'b0, 5'd0);
    checks++; if (bus.busy !== 32'h0 || bus.inflight !== 4'd0) begin errors++; $display("FAIL raw_drain got %h/%0d exp 00000000/0", bus.busy, bus.inflight); end
  endtask

  task automatic test_max_inflight();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, `MUL, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1);
      checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL fill_issue rd=%0d got %b exp 1", i, bus.issue); end
      step();
    end
    drive(1'b1, `ADDI, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    checks++; if (bus.inflight !== 4'd4 || bus.busy !== 32'h1E) begin errors++; $display("FAIL full_state got %h/%0d exp 0000001e/4", bus.busy, bus.inflight); end
    checks++; if (bus.stall !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL full_stall got issue=%b stall=%b exp 0 1", bus.issue, bus.stall); end
    step();
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall2 got %b exp 1", bus.stall); end
    wb(1'b1, 5'd1);
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL full_wbcycle got %b exp 0", bus.issue); end
    step();
    wb(1'b0, 5'd0);
    checks++; if (bus.inflight !== 4'd3 || bus.issue !== 1'b1) begin errors++; $display("FAIL slot_free got inflight=%0d issue=%b exp 3 1", bus.inflight, bus.issue); end
    step();
    drive(1'b0, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checks++; if (bus.inflight !== 4'd4 || bus.busy !== 32'h5C) begin errors++; $display("FAIL refill got %h/%0d exp 0000005c/4", bus.busy, bus.inflight); end
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin
        wb(1'b1, 5'(r));
        step();
      end
    end
    wb(1'b0, 5'd0);
    checks++; if (bus.inflight !== 4'd0 || bus.busy !== 32'h0) begin errors++; $display("FAIL full_drain got %h/%0d exp 00000000/0", bus.busy, bus.inflight); end
  endtask

  task automatic test_branch();
    // br_done while running is ignored.
    bus.br_done = 1'b1; bus.br_taken = 1'b1;
    step();
    bus.br_done = 1'b0; bus.br_taken = 1'b0;
    settle();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL run_brdone_flush got %b exp 0", bus.flush); end
    drive(1'b1, `BNE, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL bne_issue got %b exp 1", bus.issue); end
    step();
    drive(1'b1, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin bus.br_done = 1'b1; bus.br_taken = 1'b1; settle(); end
      checks++; if (bus.issue !== 1'b0 || bus.stall !== 1'b1 || bus.flush !== 1'b0) begin errors++; $display("FAIL br_wait c=%0d got issue=%b stall=%b flush=%b exp 0 1 0", c, bus.issue, bus.stall, bus.flush); end
      step();
    end
    bus.br_done = 1'b0; bus.br_taken = 1'b0;
    settle();
    checks++; if (bus.flush !== 1'b1 || bus.issue !== 1'b0) begin errors++; $display("FAIL flush_pulse got flush=%b issue=%b exp 1 0", bus.flush, bus.issue); end
    step();
    checks++; if (bus.flush !== 1'b0 || bus.issue !== 1'b1) begin errors++; $display("FAIL after_flush got flush=%b issue=%b exp 0 1", bus.flush, bus.issue); end
    step();
    // Not-taken branch returns to RUN without a flush.
    drive(1'b1, `JAL, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b1, 5'd8);
    step();
    wb(1'b0, 5'd0);
    drive(1'b1, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.br_done = 1'b1; bus.br_taken = 1'b0;
    settle();
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL jal_wait got %b exp 0", bus.issue); end
    step();
    bus.br_done = 1'b0;
    settle();
    checks++; if (bus.flush !== 1'b0 || bus.issue !== 1'b1 || bus.busy !== 32'h0) begin errors++; $display("FAIL jal_nottaken got flush=%b issue=%b busy=%h exp 0 1 00000000", bus.flush, bus.issue, bus.busy); end
    step();
    idle();
  endtask

  task automatic test_same_cycle();
    drive(1'b1, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    step();
    checks++; if (bus.busy !== 32'h80 || bus.inflight !== 4'd1) begin errors++; $display("FAIL same_pre got %h/%0d exp 00000080/1", bus.busy, bus.inflight); end
    wb(1'b1, 5'd7);
`ifdef ISSUE_WB_BYPASS_EN
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL same_issue got %b exp 1", bus.issue); end
    step();
    wb(1'b0, 5'd0);
`else
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL same_waw_stall got %b exp 0", bus.issue); end
    step();
    wb(1'b0, 5'd0);
    checks++; if (bus.busy !== 32'h0 || bus.issue !== 1'b1) begin errors++; $display("FAIL same_cleared got busy=%h issue=%b exp 00000000 1", bus.busy, bus.issue); end
    step();
`endif
    drive(1'b0, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checks++; if (bus.busy !== 32'h80 || bus.inflight !== 4'd1) begin errors++; $display("FAIL same_post got %h/%0d exp 00000080/1", bus.busy, bus.inflight); end
    wb(1'b1, 5'd7);
    step();
    wb(1'b0, 5'd0);
  endtask

  task automatic test_x0_and_reset();
    drive(1'b1, `ADDI, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL x0_issue got %b exp 1", bus.issue); end
    step();
    checks++; if (bus.busy !== 32'h0 || bus.inflight !== 4'd0) begin errors++; $display("FAIL x0_state got %h/%0d exp 00000000/0", bus.busy, bus.inflight); end
    drive(1'b1, `LW, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
    step();
    drive(1'b1, `LW, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
    step();
    drive(1'b1, `JR, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL jr_issue got %b exp 1", bus.issue); end
    step();
    drive(1'b1, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    wb(1'b1, 5'd0);
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL jr_wait got %b exp 0", bus.issue); end
    step();
    checks++; if (bus.inflight !== 4'd2 || bus.busy !== 32'h6) begin errors++; $display("FAIL wb_x0_ignored got %h/%0d exp 00000006/2", bus.busy, bus.inflight); end
    rst = 1'b1;
    wb(1'b1, 5'd1);
    step();
    rst = 1'b0;
    wb(1'b0, 5'd0);
    checks++; if (bus.busy !== 32'h0 || bus.inflight !== 4'd0 || bus.flush !== 1'b0) begin errors++; $display("FAIL midreset got %h/%0d/%b exp 00000000/0/0", bus.busy, bus.inflight, bus.flush); end
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL midreset_run got %b exp 1", bus.issue); end
    drive(1'b0, `ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b1, 5'd3);
    step();
    wb(1'b0, 5'd0);
    checks++; if (bus.inflight !== 4'd0 || bus.busy !== 32'h0) begin errors++; $display("FAIL wb_empty_ignored got %h/%0d exp 00000000/0", bus.busy, bus.inflight); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_raw_hazard();
    test_max_inflight();
    test_branch();
    test_same_cycle();
    test_x0_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
